// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : Multi-cycle EX-stage multiply/divide unit owning the HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mulE,
  input  logic              divE,
  input  logic              signE,
  input  logic              mthiE,
  input  logic              mtloE,
  input  logic [DATA_W-1:0] srcA,
  input  logic [DATA_W-1:0] srcB,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = ($clog2(MUL_CYCLES) > 5) ? $clog2(MUL_CYCLES) : 5;
  localparam logic [CNT_W-1:0] c_mul_init = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_div_init = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL    = 2'd1,
    S_DIV    = 2'd2,
    S_DIVFIX = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  // r_quo doubles as the multiplicand, r_dvs as the multiplier during MUL
  logic [DATA_W-1:0]   r_quo;
  logic [DATA_W-1:0]   r_rem;
  logic [DATA_W-1:0]   r_dvs;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_sign;
  logic                r_qneg;
  logic                r_rneg;
  logic                r_done;

  logic [DATA_W-1:0]   w_abs_a;
  logic [DATA_W-1:0]   w_abs_b;
  logic [DATA_W:0]     w_shift;
  logic [DATA_W:0]     w_diff;
  logic [2*DATA_W-1:0] w_ext_a;
  logic [2*DATA_W-1:0] w_ext_b;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quo_fix;
  logic [DATA_W-1:0]   w_rem_fix;

  assign w_abs_a = (signE && srcA[DATA_W-1]) ? -srcA : srcA;
  assign w_abs_b = (signE && srcB[DATA_W-1]) ? -srcB : srcB;

  // Restoring step: a set borrow bit means the trial subtraction went negative
  assign w_shift = {r_rem, r_quo[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  assign w_ext_a = {{DATA_W{r_sign & r_quo[DATA_W-1]}}, r_quo};
  assign w_ext_b = {{DATA_W{r_sign & r_dvs[DATA_W-1]}}, r_dvs};
  assign w_prod  = w_ext_a * w_ext_b;

  assign w_quo_fix = r_qneg ? -r_quo : r_quo;
  assign w_rem_fix = r_rneg ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (divE) begin
          w_next = (srcB == '0) ? S_DIVFIX : S_DIV;
        end else if (mulE) begin
          w_next = S_MUL;
        end
      end
      S_MUL: begin
        if (r_cnt == '0) begin
          w_next = S_IDLE;
        end
      end
      S_DIV: begin
        if (r_cnt == '0) begin
          w_next = S_DIVFIX;
        end
      end
      S_DIVFIX: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_sign <= 1'b0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (divE) begin
            r_cnt <= c_div_init;
            // Divide by zero skips iteration: DIVFIX publishes these unchanged
            if (srcB == '0) begin
              r_quo  <= '1;
              r_rem  <= srcA;
              r_qneg <= 1'b0;
              r_rneg <= 1'b0;
            end else begin
              r_quo  <= w_abs_a;
              r_rem  <= '0;
              r_dvs  <= w_abs_b;
              r_qneg <= signE & (srcA[DATA_W-1] ^ srcB[DATA_W-1]);
              r_rneg <= signE & srcA[DATA_W-1];
            end
          end else if (mulE) begin
            r_cnt  <= c_mul_init;
            r_quo  <= srcA;
            r_dvs  <= srcB;
            r_sign <= signE;
          end else begin
            if (mthiE) r_hi <= srcA;
            if (mtloE) r_lo <= srcA;
          end
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            {r_hi, r_lo} <= w_prod;
            r_done       <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end
        S_DIV: begin
          if (!w_diff[DATA_W]) begin
            r_rem <= w_diff[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[DATA_W-1:0];
            r_quo <= {r_quo[DATA_W-2:0], 1'b0};
          end
          r_cnt <= r_cnt - c_one;
        end
        S_DIVFIX: begin
          r_hi   <= w_rem_fix;
          r_lo   <= w_quo_fix;
          r_done <= 1'b1;
        end
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Purpose  : Scoreboard bench for ex_muldiv_unit with a behavioural HI/LO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mulE = 1'b0, divE = 1'b0, signE = 1'b0, mthiE = 1'b0, mtloE = 1'b0;
  logic [31:0] srcA = '0, srcB = '0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] sb_q[$];
  logic [31:0] cur_hi = '0, cur_lo = '0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.DATA_W(32), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .mulE(mulE), .divE(divE), .signE(signE),
    .mthiE(mthiE), .mtloE(mtloE), .srcA(srcA), .srcB(srcB),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // {hi, lo} straight from the arithmetic definition of each operation
  function automatic logic [63:0] model(input bit is_div, input bit sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      if (sgn) r = 64'(sa * sb);
      else     r = {32'b0, a} * {32'b0, b};
    end else if (b == 32'd0) begin
      r = {a, 32'hFFFF_FFFF};
    end else if (sgn) begin
      r = {32'(sa % sb), 32'(sa / sb)};
    end else begin
      r = {a % b, a / b};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_spurious actual=%h_%h required=no_done", hi, lo);
      end else begin
        chk("result", {hi, lo}, sb_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic run_op(input bit is_div, input bit is_mul, input bit sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit mt_start, input bit poke);
    int lat, cnt;
    logic [63:0] e;
    wait_idle();
    divE = is_div; mulE = is_mul; signE = sgn; srcA = a; srcB = b;
    mthiE = mt_start; mtloE = mt_start;
    e = model(is_div, sgn, a, b);
    sb_q.push_back(e);
    cur_hi = e[63:32];
    cur_lo = e[31:0];
    lat = is_div ? ((b == 32'd0) ? 1 : 33) : MC;
    @(negedge clk);
    divE = 1'b0; mulE = 1'b0; mthiE = 1'b0; mtloE = 1'b0;
    srcA = $urandom; srcB = $urandom; signE = 1'($urandom);
    cnt = 0;
    while (busy && cnt < 200) begin
      if (poke) begin
        mthiE = 1'b1; mtloE = 1'b1; mulE = 1'b1; srcA = 32'hAA;
      end
      cnt++;
      @(negedge clk);
    end
    mthiE = 1'b0; mtloE = 1'b0; mulE = 1'b0;
    chk("latency", 64'(cnt), 64'(lat));
  endtask

  task automatic run_mt(input bit h, input bit l, input logic [31:0] a);
    wait_idle();
    mthiE = h; mtloE = l; srcA = a;
    @(negedge clk);
    mthiE = 1'b0; mtloE = 1'b0;
    if (h) cur_hi = a;
    if (l) cur_lo = a;
    chk("mt_hilo", {hi, lo}, {cur_hi, cur_lo});
    chk("mt_busy_done", {busy, done}, 2'b00);
  endtask

  task automatic run_b2b(input logic [31:0] a1, input logic [31:0] b1,
                         input logic [31:0] a2, input logic [31:0] b2);
    int cnt;
    logic [63:0] e;
    wait_idle();
    mulE = 1'b1; signE = 1'b1; srcA = a1; srcB = b1;
    sb_q.push_back(model(1'b0, 1'b1, a1, b1));
    @(negedge clk);
    mulE = 1'b0; divE = 1'b1; signE = 1'b0; srcA = a2; srcB = b2;
    e = model(1'b1, 1'b0, a2, b2);
    sb_q.push_back(e);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("b2b_mul_latency", 64'(cnt), 64'(MC));
    @(negedge clk);
    chk("b2b_div_started", 64'(busy), 64'd1);
    divE = 1'b0; srcA = $urandom; srcB = $urandom;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("b2b_div_latency", 64'(cnt), 64'd33);
    cur_hi = e[63:32];
    cur_lo = e[31:0];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {hi, lo, busy, done}, 66'd0);

    run_op(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 1'b0, 32'h1234, 32'd0, 1'b0, 1'b0);
    run_op(1'b1, 1'b1, 1'b0, 32'd10, 32'd3, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'd12345, 1'b0, 1'b1);
    run_op(1'b0, 1'b1, 1'b0, 32'h0001_0001, 32'h0000_FFFF, 1'b1, 1'b1);
    run_mt(1'b1, 1'b1, 32'h55);
    run_mt(1'b1, 1'b0, 32'h1357_9BDF);
    run_mt(1'b0, 1'b1, 32'h2468_ACE0);
    run_b2b(32'hFFFF_FF00, 32'h0000_1000, 32'd1000, 32'd9);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 1) == 0)
        run_op(1'b1, 1'($urandom), 1'($urandom), ra, rb, 1'($urandom), 1'($urandom));
      else
        run_op(1'b0, 1'b1, 1'($urandom), ra, rb, 1'($urandom), 1'($urandom));
    end

    // Abort a divide mid-flight while the start stays asserted through reset
    wait_idle();
    divE = 1'b1; signE = 1'b1; srcA = 32'hFFFF_FFF9; srcB = 32'd2;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_mid_div", {hi, lo, busy, done}, 66'd0);
    rst = 1'b0;
    divE = 1'b0;
    cur_hi = '0;
    cur_lo = '0;
    repeat (3) @(negedge clk);
    chk("reset_no_launch", {hi, lo, busy, done}, 66'd0);
    run_mt(1'b1, 1'b0, 32'hCAFE_F00D);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
